// File: rtl/ext_mem_pkg.sv
// ext_mem_pkg
// Shared definitions for the external-memory responder:
//   - chan_state_t : per-channel bus FSM encoding
//   - in_range()   : address window test against [base, base+depth)
//   - size_mask()  : write-enable bit mask for a data_ram_size value
package ext_mem_pkg;

  localparam int unsigned MASK_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } chan_state_t;

  // Evaluated in 33 bits so base+depth reaching 2**32 cannot wrap.
  function automatic logic in_range(input logic [31:0] a,
                                    input int unsigned base,
                                    input int unsigned depth);
    logic [32:0] a_w;
    logic [32:0] lo;
    logic [32:0] hi;
    a_w = {1'b0, a};
    lo  = {1'b0, base};
    hi  = {1'b0, base} + {1'b0, depth};
    return (a_w >= lo) && (a_w < hi);
  endfunction

  // Sizes at or above the lane width write the whole lane; smaller sizes
  // write only the low 'size' bits, and size 0 writes nothing.
  function automatic logic [MASK_W-1:0] size_mask(input logic [31:0] size,
                                                   input int unsigned bitsize);
    if (size >= bitsize) begin
      return '1;
    end
    return (MASK_W'(1) << size) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/ext_mem_chan_ctrl.sv
// ext_mem_chan_ctrl
// One bus channel of the external-memory responder: request FSM, cycle
// counter, read-data shift pipe and DataRdy / write-commit generation.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   oe, we           read / write enable, held by the master until DataRdy
//   hit              channel address lies inside the mapped window
//   rd_byte          array byte at the channel address (combinational)
//   data_rdy         one-cycle completion strobe
//   rdata            read byte, zero whenever data_rdy is low
//   commit           write the masked byte at the coming clock edge
module ext_mem_chan_ctrl
  import ext_mem_pkg::*;
#(
  parameter int unsigned BITSIZE     = 8,
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               oe,
  input  logic               we,
  input  logic               hit,
  input  logic [BITSIZE-1:0] rd_byte,
  output logic               data_rdy,
  output logic [BITSIZE-1:0] rdata,
  output logic               commit
);

  localparam int unsigned MAX_D  = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int unsigned CNT_W  = (MAX_D > 1) ? $clog2(MAX_D) : 1;
  localparam int unsigned RD_LAST = READ_DELAY - 1;
  localparam int unsigned WR_LAST = WRITE_DELAY - 1;
  localparam int unsigned PIPE_D  = READ_DELAY - 1;

  chan_state_t        state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               rdy_c;
  logic               commit_c;
  logic               sample;
  logic [BITSIZE-1:0] pipe [PIPE_D];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The first cycle of a request is spent in IDLE and counts as cnt==0;
  // that is why a WRITE_DELAY of 1 completes without leaving IDLE.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rdy_c    = 1'b0;
    commit_c = 1'b0;
    sample   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (oe && hit) begin
          // oe wins over a simultaneous we: the access is served as a read.
          sample   = 1'b1;
          state_nx = ST_RD;
          cnt_nx   = CNT_W'(1);
        end else if (we && hit) begin
          if (WR_LAST == 0) begin
            rdy_c    = 1'b1;
            commit_c = 1'b1;
          end else begin
            state_nx = ST_WR;
            cnt_nx   = CNT_W'(1);
          end
        end
      end
      ST_RD: begin
        if (!oe) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(RD_LAST)) begin
          rdy_c    = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_WR: begin
        // A write that loses we, or turns into oe&we, is abandoned uncommitted.
        if (!we || oe) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(WR_LAST)) begin
          rdy_c    = 1'b1;
          commit_c = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Read sample stage: byte captured on the first oe cycle, then shifted
  // so it reaches the last stage exactly when cnt hits READ_DELAY-1.
  always_ff @(posedge clock) begin
    if (sample) begin
      pipe[0] <= rd_byte;
    end
    for (int k = 1; k < int'(PIPE_D); k++) begin
      pipe[k] <= pipe[k-1];
    end
  end

  // Strobes are gated by reset so they drop the moment reset asserts,
  // which also kills a write that has not committed yet.
  assign data_rdy = rdy_c & reset;
  assign commit   = commit_c & reset;
  assign rdata    = data_rdy ? pipe[PIPE_D-1] : '0;

endmodule

// File: rtl/ext_mem_responder.sv
// ext_mem_responder
// External-memory slave for the accelerator master bus. CHANNELS byte-wide
// ports share one register-based byte array mapped at
// [BASE_ADDR, BASE_ADDR+DEPTH), with programmable read/write latency and a
// host preload / readback port.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   Mout_oe_ram           per-channel read enable (held until DataRdy)
//   Mout_we_ram           per-channel write enable (held until DataRdy)
//   Mout_addr_ram         per-channel byte address
//   Mout_Wdata_ram        per-channel write data
//   Mout_data_ram_size    per-channel access size in bits
//   M_Rdata_ram           per-channel read data, zero unless DataRdy
//   M_DataRdy             per-channel one-cycle completion strobe
//   load_en/addr/data     host byte write (absolute address)
//   dump_addr/dump_data   host readback, one-cycle registered latency
//   err_flag              sticky protocol error
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned BITSIZE     = 8,
  parameter int unsigned SIZE_W      = 4,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned DEPTH       = 8192,
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          Mout_oe_ram,
  input  logic [CHANNELS-1:0]          Mout_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [CHANNELS*BITSIZE-1:0]  Mout_Wdata_ram,
  input  logic [CHANNELS*SIZE_W-1:0]   Mout_data_ram_size,
  output logic [CHANNELS*BITSIZE-1:0]  M_Rdata_ram,
  output logic [CHANNELS-1:0]          M_DataRdy,
  input  logic                         load_en,
  input  logic [ADDR_W-1:0]            load_addr,
  input  logic [BITSIZE-1:0]           load_data,
  input  logic [ADDR_W-1:0]            dump_addr,
  output logic [BITSIZE-1:0]           dump_data,
  output logic                         err_flag
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Many simultaneous access points: kept as a plain register array.
  logic [BITSIZE-1:0] mem [DEPTH];

  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] commit;
  logic [CHANNELS-1:0] rdy;
  logic [IDX_W-1:0]    idx      [CHANNELS];
  logic [BITSIZE-1:0]  rd_byte  [CHANNELS];
  logic [BITSIZE-1:0]  new_byte [CHANNELS];
  logic [BITSIZE-1:0]  rdata_ch [CHANNELS];
  logic [MASK_W-1:0]   mask_full[CHANNELS];
  logic [BITSIZE-1:0]  mask     [CHANNELS];
  logic [BITSIZE-1:0]  wdata    [CHANNELS];

  logic               load_hit;
  logic [IDX_W-1:0]   load_idx;
  logic               dump_hit;
  logic [IDX_W-1:0]   dump_idx;

  // Per-channel address decode, array read and masked merge of write data.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      hit[i]       = in_range(32'(Mout_addr_ram[i*ADDR_W +: ADDR_W]), BASE_ADDR, DEPTH);
      idx[i]       = IDX_W'(Mout_addr_ram[i*ADDR_W +: ADDR_W] - ADDR_W'(BASE_ADDR));
      rd_byte[i]   = hit[i] ? mem[idx[i]] : '0;
      mask_full[i] = size_mask(32'(Mout_data_ram_size[i*SIZE_W +: SIZE_W]), BITSIZE);
      mask[i]      = mask_full[i][BITSIZE-1:0];
      wdata[i]     = Mout_Wdata_ram[i*BITSIZE +: BITSIZE];
      new_byte[i]  = (wdata[i] & mask[i]) | (rd_byte[i] & ~mask[i]);
    end
  end

  always_comb begin
    load_hit = in_range(32'(load_addr), BASE_ADDR, DEPTH);
    load_idx = IDX_W'(load_addr - ADDR_W'(BASE_ADDR));
    dump_hit = in_range(32'(dump_addr), BASE_ADDR, DEPTH);
    dump_idx = IDX_W'(dump_addr - ADDR_W'(BASE_ADDR));
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
    ext_mem_chan_ctrl #(
      .BITSIZE    (BITSIZE),
      .READ_DELAY (READ_DELAY),
      .WRITE_DELAY(WRITE_DELAY)
    ) u_ctrl (
      .clock   (clock),
      .reset   (reset),
      .oe      (Mout_oe_ram[g]),
      .we      (Mout_we_ram[g]),
      .hit     (hit[g]),
      .rd_byte (rd_byte[g]),
      .data_rdy(rdy[g]),
      .rdata   (rdata_ch[g]),
      .commit  (commit[g])
    );
    assign M_Rdata_ram[g*BITSIZE +: BITSIZE] = rdata_ch[g];
  end

  assign M_DataRdy = rdy;

  // Later assignments override earlier ones: higher channel beats lower,
  // and the host load beats every bus write to the same byte.
  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (commit[i]) begin
        mem[idx[i]] <= new_byte[i];
      end
    end
    if (load_en && load_hit) begin
      mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dump_data <= '0;
    end else begin
      dump_data <= dump_hit ? mem[dump_idx] : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_flag <= 1'b0;
    end else if ((|(Mout_oe_ram & Mout_we_ram)) ||
                 (load_en && (|(Mout_oe_ram | Mout_we_ram)))) begin
      err_flag <= 1'b1;
    end
  end

endmodule
